i2c_target_regs: RTL and testbench

- Synthesizable I2C target (responder) with an internal 8-bit register bank. It is the far end of the SoC's I2C master and will replace the behavioural slave model in the I2C testbench.
- The host side (CPU bus glue or top-level logic) reads and writes the bank directly.
- SCL/SDA are open-drain: the block only ever pulls SDA low and never drives SCL.

---
 rtl/i2c_target_regs.sv | 149 ++++++++++++++
 tb/tb_i2c_target_regs.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target (responder) with a 2**PTR_W x 8 register bank and a direct host port.
// Optional: define I2C_TARGET_AUTOINC_EN to advance the register pointer after every data byte.
module i2c_target_regs #(
    parameter logic [6:0] I2C_ADDR = 7'h50,
    parameter int         PTR_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    input  logic [PTR_W-1:0] host_addr,
    input  logic [7:0]       host_wdata,
    input  logic             host_we,
    output logic [7:0]       host_rdata,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_index,
    output logic             busy
);
`ifdef I2C_TARGET_AUTOINC_EN
    localparam logic AUTOINC = 1'b1;
`else
    localparam logic AUTOINC = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, ADDR, ACK, PTR, WDATA, RDATA, RACK} state_t;
    state_t state, ack_next;
    logic [7:0] bank [2**PTR_W];
    logic [PTR_W-1:0] ptr, ptr_adv;
    logic [7:0] sr, rx_byte;
    logic [3:0] cnt;
    logic acked;
    logic scl_m, scl_s, scl_p, sda_m, sda_s, sda_p;
    logic scl_rise, scl_fall, start, stop;
    assign scl_rise = scl_s & ~scl_p;
    assign scl_fall = ~scl_s & scl_p;
    assign start    = scl_s & scl_p & sda_p & ~sda_s;
    assign stop     = scl_s & scl_p & ~sda_p & sda_s;
    assign rx_byte  = {sr[6:0], sda_s};
    assign ptr_adv  = ptr + PTR_W'(AUTOINC);
    assign host_rdata = bank[host_addr];

    // two-flop synchronizers followed by a previous-value flop for edge detection; idle bus level is 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) {scl_m, scl_s, scl_p, sda_m, sda_s, sda_p} <= '1;
        else {scl_m, scl_s, scl_p, sda_m, sda_s, sda_p} <= {scl_i, scl_m, scl_s, sda_i, sda_m, sda_s};
    end

    // protocol FSM and register bank; an I2C store is written after the host write so it wins on the same index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ack_next  <= IDLE;
            bank      <= '{default: '0};
            ptr       <= '0;
            sr        <= '0;
            cnt       <= '0;
            acked     <= 1'b0;
            sda_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
            busy      <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            if (host_we) bank[host_addr] <= host_wdata;
            if (start) begin
                state  <= ADDR;
                cnt    <= '0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (stop) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        sr  <= rx_byte;
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            if (rx_byte[7:1] == I2C_ADDR) begin
                                busy     <= 1'b1;
                                acked    <= 1'b0;
                                ack_next <= rx_byte[0] ? RDATA : PTR;
                                state    <= ACK;
                            end else state <= IDLE;
                        end
                    end
                    // first SCL fall pulls SDA for the ACK slot, second fall leaves the slot
                    ACK: if (scl_fall) begin
                        if (!acked) begin
                            acked  <= 1'b1;
                            sda_oe <= 1'b1;
                        end else begin
                            cnt    <= '0;
                            sr     <= bank[ptr];
                            sda_oe <= (ack_next == RDATA) & ~bank[ptr][7];
                            state  <= ack_next;
                        end
                    end
                    PTR: if (scl_rise) begin
                        sr  <= rx_byte;
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            ptr      <= rx_byte[PTR_W-1:0];
                            acked    <= 1'b0;
                            ack_next <= WDATA;
                            state    <= ACK;
                        end
                    end
                    WDATA: if (scl_rise) begin
                        sr  <= rx_byte;
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            bank[ptr] <= rx_byte;
                            wr_strobe <= 1'b1;
                            wr_index  <= ptr;
                            ptr       <= ptr_adv;
                            acked     <= 1'b0;
                            ack_next  <= WDATA;
                            state     <= ACK;
                        end
                    end
                    // bit 7 was driven on entry; cnt counts SCL rises so ~cnt[2:0] selects the next bit
                    RDATA: if (scl_rise) cnt <= cnt + 4'd1;
                    else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            sda_oe <= 1'b0;
                            acked  <= 1'b0;
                            state  <= RACK;
                        end else sda_oe <= ~sr[~cnt[2:0]];
                    end
                    RACK: if (scl_rise) begin
                        ptr <= ptr_adv;
                        if (sda_s) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else acked <= 1'b1;
                    end else if (scl_fall && acked) begin
                        sr     <= bank[ptr];
                        sda_oe <= ~bank[ptr][7];
                        cnt    <= '0;
                        state  <= RDATA;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: directed bench for i2c_target_regs with a bit-banged open-drain I2C master and host-port vector tables.
`timescale 1ns/1ps
module tb_i2c_target_regs;
`ifdef I2C_TARGET_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif
    localparam int Q = 20;

    logic clk = 1'b0, reset = 1'b1, scl = 1'b1, sda_m = 1'b1, host_we = 1'b0;
    logic [3:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic sda, sda_oe, wr_strobe, busy;
    logic [3:0] wr_index;
    logic [7:0] host_rdata;
    assign sda = sda_m & ~sda_oe;

    i2c_target_regs dut (
        .clk(clk), .reset(reset), .scl_i(scl), .sda_i(sda), .sda_oe(sda_oe),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_we(host_we), .host_rdata(host_rdata),
        .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int oe_cnt = 0, scnt = 0;
    logic [3:0] slog [64];

    // count cycles with SDA pulled and log every write strobe index
    always @(negedge clk) begin
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if (wr_strobe) begin
            slog[6'(scnt)] <= wr_index;
            scnt <= scnt + 1;
        end
    end

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;
    vec_t host_v [10];
    vec_t bank_v [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply(input vec_t v, input string name);
        host_we = v.we;
        host_addr = v.addr;
        host_wdata = v.wdata;
        tick(1);
        host_we = 1'b0;
        check(name, host_rdata, v.exp);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; tick(Q);
        scl = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; tick(Q);
        scl = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; tick(Q);
        scl = 1'b1; tick(2 * Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl = 1'b1; tick(Q);
        b = sda; tick(Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic nack);
        for (int i = 7; i >= 0; i--) read_bit(b[i]);
        write_bit(nack);
    endtask

    // last bit's SCL rise lands on the same clk edge as a host write: 2 sync flops then the store edge
    task automatic write_byte_collide(input logic [7:0] b, input logic [3:0] a, input logic [7:0] hv, output logic ack);
        for (int i = 7; i > 0; i--) write_bit(b[i]);
        sda_m = b[0]; tick(Q);
        scl = 1'b1; tick(2);
        host_we = 1'b1; host_addr = a; host_wdata = hv;
        tick(1);
        host_we = 1'b0;
        check("collision strobe", wr_strobe, 1);
        check("collision index", wr_index, a);
        tick(2 * Q - 3);
        scl = 1'b0; tick(Q);
        read_bit(ack);
    endtask

    initial begin
        logic ack;
        logic [7:0] d;
        logic b;
        int s0, o0;
        host_v[0] = '{1'b1, 4'd3,  8'h11, 8'h11};
        host_v[1] = '{1'b1, 4'd7,  8'hEE, 8'hEE};
        host_v[2] = '{1'b1, 4'd15, 8'h80, 8'h80};
        host_v[3] = '{1'b1, 4'd9,  8'h6C, 8'h6C};
        host_v[4] = '{1'b0, 4'd3,  8'h00, 8'h11};
        host_v[5] = '{1'b0, 4'd7,  8'h00, 8'hEE};
        host_v[6] = '{1'b0, 4'd15, 8'h00, 8'h80};
        host_v[7] = '{1'b0, 4'd0,  8'h00, 8'h00};
        host_v[8] = '{1'b1, 4'd7,  8'h00, 8'h00};
        host_v[9] = '{1'b0, 4'd9,  8'h00, 8'h6C};
        bank_v[0] = '{1'b0, 4'd3,  8'h00, AI ? 8'hA5 : 8'h5A};
        bank_v[1] = '{1'b0, 4'd4,  8'h00, AI ? 8'h5A : 8'h00};
        bank_v[2] = '{1'b0, 4'd15, 8'h00, AI ? 8'hC3 : 8'h3C};
        bank_v[3] = '{1'b0, 4'd0,  8'h00, AI ? 8'h3C : 8'h00};
        bank_v[4] = '{1'b0, 4'd5,  8'h00, 8'h99};
        bank_v[5] = '{1'b0, 4'd9,  8'h00, 8'h6C};
        bank_v[6] = '{1'b0, 4'd7,  8'h00, 8'h00};
        bank_v[7] = '{1'b0, 4'd6,  8'h00, 8'h00};
        bank_v[8] = '{1'b0, 4'd1,  8'h00, 8'h00};

        tick(4);
        reset = 1'b0;
        tick(2);
        check("reset sda_oe", sda_oe, 0);
        check("reset busy", busy, 0);
        check("reset wr_strobe", wr_strobe, 0);
        check("reset wr_index", wr_index, 0);
        for (int i = 0; i < 10; i++) apply(host_v[i], $sformatf("host_v[%0d]", i));

        s0 = scnt;
        i2c_start;
        write_byte(8'hA0, ack); check("wr addr ack", ack, 0);
        check("busy after addr ack", busy, 1);
        write_byte(8'h03, ack); check("wr ptr ack", ack, 0);
        write_byte(8'hA5, ack); check("wr data0 ack", ack, 0);
        write_byte(8'h5A, ack); check("wr data1 ack", ack, 0);
        check("busy before stop", busy, 1);
        i2c_stop;
        tick(4);
        check("busy after stop", busy, 0);
        check("strobe count", scnt - s0, 2);
        check("strobe index 0", slog[6'(s0)], 3);
        check("strobe index 1", slog[6'(s0 + 1)], AI ? 4 : 3);

        i2c_start;
        write_byte(8'hA0, ack); check("rd addr w ack", ack, 0);
        write_byte(8'h03, ack); check("rd ptr ack", ack, 0);
        i2c_start;
        write_byte(8'hA1, ack); check("rd addr r ack", ack, 0);
        read_byte(d, 1'b0); check("rd byte 0", d, AI ? 8'hA5 : 8'h5A);
        read_byte(d, 1'b1); check("rd byte 1", d, 8'h5A);
        check("busy after nack", busy, 0);
        check("sda_oe after nack", sda_oe, 0);
        i2c_stop;

        o0 = oe_cnt;
        i2c_start;
        write_byte(8'hA2, ack); check("mismatch addr nack", ack, 1);
        check("mismatch busy", busy, 0);
        write_byte(8'h00, ack); check("mismatch data nack", ack, 1);
        i2c_stop;
        tick(4);
        check("mismatch sda_oe cycles", oe_cnt - o0, 0);

        i2c_start;
        write_byte(8'hA0, ack); check("wrap addr ack", ack, 0);
        write_byte(8'h0F, ack); check("wrap ptr ack", ack, 0);
        write_byte(8'hC3, ack); check("wrap data0 ack", ack, 0);
        write_byte(8'h3C, ack); check("wrap data1 ack", ack, 0);
        i2c_stop;

        i2c_start;
        write_byte(8'hA0, ack); check("coll addr ack", ack, 0);
        write_byte(8'h05, ack); check("coll ptr ack", ack, 0);
        write_byte_collide(8'h99, 4'd5, 8'h77, ack); check("coll data ack", ack, 0);
        i2c_stop;
        for (int i = 0; i < 9; i++) apply(bank_v[i], $sformatf("bank_v[%0d]", i));

        i2c_start;
        write_byte(8'hA0, ack); check("rst addr ack", ack, 0);
        write_byte(8'h09, ack); check("rst ptr ack", ack, 0);
        i2c_start;
        write_byte(8'hA1, ack); check("rst raddr ack", ack, 0);
        read_bit(b); check("rst bit7", b, 0);
        read_bit(b); check("rst bit6", b, 1);
        read_bit(b); check("rst bit5", b, 1);
        sda_m = 1'b1; tick(Q);
        scl = 1'b1; tick(Q);
        check("rst bit4 driven", sda_oe, 1);
        reset = 1'b1;
        #1;
        check("rst sda_oe async", sda_oe, 0);
        check("rst busy", busy, 0);
        tick(2);
        for (int i = 0; i < 16; i += 3) begin
            host_addr = 4'(i);
            #1;
            check($sformatf("rst bank[%0d]", i), host_rdata, 0);
        end
        tick(1);
        reset = 1'b0;
        tick(2);
        scl = 1'b0; tick(Q);
        i2c_stop;
        i2c_start;
        write_byte(8'hA1, ack); check("post-rst addr ack", ack, 0);
        read_byte(d, 1'b1); check("post-rst read", d, 8'h00);
        check("post-rst busy", busy, 0);
        i2c_stop;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
